// File: rtl/exec_pkg.sv
// Shared types and constants for the pipelined execute unit.
package exec_pkg;

    // Instruction class carried down the pipe; ModeRsvd executes as an ALU op.
    typedef enum logic [1:0] {
        ModeAlu  = 2'd0,
        ModeMovz = 2'd1,
        ModeMovk = 2'd2,
        ModeRsvd = 2'd3
    } mode_e;

    localparam logic [2:0] AluPassB = 3'b000;
    localparam logic [2:0] AluAdd   = 3'b010;
    localparam logic [2:0] AluSub   = 3'b011;
    localparam logic [2:0] AluAnd   = 3'b100;
    localparam logic [2:0] AluOr    = 3'b101;
    localparam logic [2:0] AluXor   = 3'b110;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    // Highest register number is the zero register.
    function automatic int unsigned xzr(input int unsigned reg_aw);
        return (32'd1 << reg_aw) - 32'd1;
    endfunction

endpackage

// File: rtl/exec_alu_mov.sv
// Combinational ALU plus MOVZ/MOVK lane insert; flags are only meaningful for ALU ops.
module exec_alu_mov
    import exec_pkg::*;
#(
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned LANE_W  = 16,
    parameter int unsigned SHAMT_W = 2
) (
    input  mode_e              mode_i,
    input  logic [2:0]         aluop_i,
    input  logic [DATA_W-1:0]  opa_i,
    input  logic [DATA_W-1:0]  opb_i,
    input  logic [DATA_W-1:0]  rs2_i,
    input  logic [LANE_W-1:0]  imm16_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    output logic [DATA_W-1:0]  result_o,
    output flags_t             flags_o
);

    logic              is_sub;
    logic              arith;
    logic [DATA_W-1:0] b_eff;
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] lane_val;
    logic [DATA_W-1:0] lane_mask;

    // Result and NZCV; subtract is A + ~B + 1 so C means "no borrow".
    always_comb begin
        is_sub    = (aluop_i == AluSub);
        arith     = is_sub || (aluop_i == AluAdd);
        b_eff     = is_sub ? ~opb_i : opb_i;
        sum       = {1'b0, opa_i} + {1'b0, b_eff} + {{DATA_W{1'b0}}, is_sub};
        lane_val  = DATA_W'(imm16_i) << (LANE_W * shamt_i);
        lane_mask = DATA_W'({LANE_W{1'b1}}) << (LANE_W * shamt_i);

        case (aluop_i)
            AluAdd, AluSub: alu_res = sum[DATA_W-1:0];
            AluAnd:         alu_res = opa_i & opb_i;
            AluOr:          alu_res = opa_i | opb_i;
            AluXor:         alu_res = opa_i ^ opb_i;
            AluPassB:       alu_res = opb_i;
            default:        alu_res = opb_i;  // unused encodings behave as B-pass
        endcase

        case (mode_i)
            ModeMovz: result_o = lane_val;
            ModeMovk: result_o = (rs2_i & ~lane_mask) | lane_val;
            default:  result_o = alu_res;
        endcase

        flags_o.n = alu_res[DATA_W-1];
        flags_o.z = (alu_res == '0);
        flags_o.c = arith & sum[DATA_W];
        flags_o.v = arith & (opa_i[DATA_W-1] == b_eff[DATA_W-1])
                          & (sum[DATA_W-1] != opa_i[DATA_W-1]);
    end

endmodule

// File: rtl/pipelined_exec_unit.sv
// Two-stage execute unit: operand stage A, result stage B, NZCV register, local forwarding.
module pipelined_exec_unit
    import exec_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned LANE_W = 16,
    parameter int unsigned REG_AW = 5,
    localparam int unsigned NLANES  = DATA_W / LANE_W,
    localparam int unsigned SHAMT_W = (NLANES > 1) ? $clog2(NLANES) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_mode,
    input  logic [2:0]         in_aluop,
    input  logic               in_use_imm,
    input  logic [DATA_W-1:0]  in_imm,
    input  logic [LANE_W-1:0]  in_imm16,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic               in_flagset,
    input  logic [REG_AW-1:0]  in_rs1,
    input  logic [REG_AW-1:0]  in_rs2,
    input  logic [REG_AW-1:0]  in_rd,
    input  logic               in_rd_we,
    input  logic [DATA_W-1:0]  in_a,
    input  logic [DATA_W-1:0]  in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_result,
    output logic [DATA_W-1:0]  out_b,
    output logic [REG_AW-1:0]  out_rd,
    output logic               out_rd_we,
    output logic [3:0]         flags_q,
    output logic               zero_check
);

    localparam logic [REG_AW-1:0] XzrReg = REG_AW'(xzr(REG_AW));

    logic               a_valid_q, a_valid_d, a_flagset_q, a_flagset_d, a_rd_we_q, a_rd_we_d;
    mode_e              a_mode_q, a_mode_d;
    logic [2:0]         a_aluop_q, a_aluop_d;
    logic [REG_AW-1:0]  a_rd_q, a_rd_d;
    logic [DATA_W-1:0]  a_opa_q, a_opa_d, a_opb_q, a_opb_d, a_rs2v_q, a_rs2v_d;
    logic [LANE_W-1:0]  a_imm16_q, a_imm16_d;
    logic [SHAMT_W-1:0] a_shamt_q, a_shamt_d;
    logic               b_valid_q, b_valid_d, b_rd_we_q, b_rd_we_d;
    logic [DATA_W-1:0]  b_result_q, b_result_d, b_b_q, b_b_d;
    logic [REG_AW-1:0]  b_rd_q, b_rd_d;
    flags_t             flags_d;

    logic [DATA_W-1:0]  alu_result, fwd_a, fwd_b;
    flags_t             alu_flags;
    logic               b_adv, accept, a_is_alu;

    exec_alu_mov #(
        .DATA_W  (DATA_W),
        .LANE_W  (LANE_W),
        .SHAMT_W (SHAMT_W)
    ) u_alu_mov (
        .mode_i   (a_mode_q),
        .aluop_i  (a_aluop_q),
        .opa_i    (a_opa_q),
        .opb_i    (a_opb_q),
        .rs2_i    (a_rs2v_q),
        .imm16_i  (a_imm16_q),
        .shamt_i  (a_shamt_q),
        .result_o (alu_result),
        .flags_o  (alu_flags)
    );

    // Operand forwarding: XZR is always zero, then A's live result, then B, then regfile data.
    always_comb begin
        fwd_a = in_a;
        if (in_rs1 == XzrReg)                                  fwd_a = '0;
        else if (a_valid_q && a_rd_we_q && (a_rd_q == in_rs1)) fwd_a = alu_result;
        else if (b_valid_q && b_rd_we_q && (b_rd_q == in_rs1)) fwd_a = b_result_q;
        fwd_b = in_b;
        if (in_rs2 == XzrReg)                                  fwd_b = '0;
        else if (a_valid_q && a_rd_we_q && (a_rd_q == in_rs2)) fwd_b = alu_result;
        else if (b_valid_q && b_rd_we_q && (b_rd_q == in_rs2)) fwd_b = b_result_q;
    end

    // Handshake and next-state for both stages and the flag register.
    always_comb begin
        b_adv    = !b_valid_q || out_ready;
        in_ready = !a_valid_q || b_adv;
        accept   = in_valid && in_ready && !flush;
        a_is_alu = (a_mode_q == ModeAlu) || (a_mode_q == ModeRsvd);

        a_valid_d   = a_valid_q;   a_mode_d   = a_mode_q;   a_aluop_d = a_aluop_q;
        a_flagset_d = a_flagset_q; a_rd_d     = a_rd_q;     a_rd_we_d = a_rd_we_q;
        a_opa_d     = a_opa_q;     a_opb_d    = a_opb_q;    a_rs2v_d  = a_rs2v_q;
        a_imm16_d   = a_imm16_q;   a_shamt_d  = a_shamt_q;
        b_valid_d   = b_valid_q;   b_result_d = b_result_q; b_b_d     = b_b_q;
        b_rd_d      = b_rd_q;      b_rd_we_d  = b_rd_we_q;
        flags_d     = flags_q;

        if (b_adv) begin
            b_valid_d = a_valid_q;
            if (a_valid_q) begin
                b_result_d = alu_result;
                b_b_d      = a_rs2v_q;
                b_rd_d     = a_rd_q;
                b_rd_we_d  = a_rd_we_q;
                if (a_flagset_q && a_is_alu) flags_d = alu_flags;
            end
        end

        if (in_ready) a_valid_d = in_valid;
        if (accept) begin
            a_mode_d    = mode_e'(in_mode);
            a_aluop_d   = in_aluop;
            a_flagset_d = in_flagset;
            a_rd_d      = in_rd;
            a_rd_we_d   = in_rd_we;
            a_opa_d     = fwd_a;
            a_opb_d     = in_use_imm ? in_imm : fwd_b;
            a_rs2v_d    = fwd_b;
            a_imm16_d   = in_imm16;
            a_shamt_d   = in_shamt;
        end

        // Flush kills both stages and suppresses the flag write of the instruction leaving A.
        if (flush) begin
            a_valid_d = 1'b0;
            b_valid_d = 1'b0;
            flags_d   = flags_q;
        end
    end

    // Pipeline and flag registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_valid_q <= 1'b0; a_mode_q   <= ModeAlu; a_aluop_q <= '0;
            a_flagset_q <= 1'b0; a_rd_q   <= '0;      a_rd_we_q <= 1'b0;
            a_opa_q   <= '0;   a_opb_q    <= '0;      a_rs2v_q  <= '0;
            a_imm16_q <= '0;   a_shamt_q  <= '0;
            b_valid_q <= 1'b0; b_result_q <= '0;      b_b_q     <= '0;
            b_rd_q    <= '0;   b_rd_we_q  <= 1'b0;
            flags_q   <= '0;
        end else begin
            a_valid_q <= a_valid_d; a_mode_q   <= a_mode_d;   a_aluop_q <= a_aluop_d;
            a_flagset_q <= a_flagset_d; a_rd_q <= a_rd_d;     a_rd_we_q <= a_rd_we_d;
            a_opa_q   <= a_opa_d;   a_opb_q    <= a_opb_d;    a_rs2v_q  <= a_rs2v_d;
            a_imm16_q <= a_imm16_d; a_shamt_q  <= a_shamt_d;
            b_valid_q <= b_valid_d; b_result_q <= b_result_d; b_b_q     <= b_b_d;
            b_rd_q    <= b_rd_d;    b_rd_we_q  <= b_rd_we_d;
            flags_q   <= flags_d;
        end
    end

    assign out_valid  = b_valid_q;
    assign out_result = b_result_q;
    assign out_b      = b_b_q;
    assign out_rd     = b_rd_q;
    assign out_rd_we  = b_rd_we_q;
    assign zero_check = (alu_result == '0);

endmodule

// File: tb/tb_pipelined_exec_unit.sv
// Directed bench for pipelined_exec_unit with an in-order result scoreboard.
module tb_pipelined_exec_unit;
    import exec_pkg::*;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, in_use_imm, in_flagset, in_rd_we;
    logic [1:0]  in_mode, in_shamt;
    logic [2:0]  in_aluop;
    logic [63:0] in_imm, in_a, in_b, out_result, out_b;
    logic [15:0] in_imm16;
    logic [4:0]  in_rs1, in_rs2, in_rd, out_rd;
    logic        out_valid, out_ready, out_rd_we, zero_check;
    logic [3:0]  flags_q;

    always #5 clk = ~clk;

    pipelined_exec_unit #(
        .DATA_W (64),
        .LANE_W (16),
        .REG_AW (5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_mode    (in_mode),
        .in_aluop   (in_aluop),
        .in_use_imm (in_use_imm),
        .in_imm     (in_imm),
        .in_imm16   (in_imm16),
        .in_shamt   (in_shamt),
        .in_flagset (in_flagset),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_rd      (in_rd),
        .in_rd_we   (in_rd_we),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_b      (out_b),
        .out_rd     (out_rd),
        .out_rd_we  (out_rd_we),
        .flags_q    (flags_q),
        .zero_check (zero_check)
    );

    typedef struct {
        logic [63:0] res;
        logic [63:0] b;
        logic [4:0]  rd;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [63:0] exp_res, exp_b;
    int          n_pass = 0;
    int          n_total = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Scoreboard: push on accepted issue, pop and compare on output handshake.
    always @(negedge clk) begin
        if (!reset) begin
        end else if (flush) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_output", 64'(sb.size()), 64'd1);
                end else begin
                    mon_e = sb.pop_front();
                    check("out_result", out_result, mon_e.res);
                    check("out_b", out_b, mon_e.b);
                    check("out_rd", 64'(out_rd), 64'(mon_e.rd));
                    check("out_rd_we", 64'(out_rd_we), 64'd1);
                end
            end
            if (in_valid && in_ready) sb.push_back('{exp_res, exp_b, in_rd});
        end
    end

    task automatic drive(input logic [1:0] mode, input logic [2:0] op, input logic use_imm,
                         input logic [63:0] imm, input logic [15:0] imm16,
                         input logic [1:0] shamt, input logic fs,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] er, input logic [63:0] eb);
        in_mode = mode; in_aluop = op; in_use_imm = use_imm; in_imm = imm;
        in_imm16 = imm16; in_shamt = shamt; in_flagset = fs;
        in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_rd_we = 1'b1;
        in_a = a; in_b = b; exp_res = er; exp_b = eb; in_valid = 1'b1;
    endtask

    task automatic wait_accept();
        logic ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready && !flush;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("issue_accepted", 64'(ok), 64'd1);
    endtask

    task automatic set_alu(input logic [2:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd, input logic use_imm, input logic [63:0] imm,
                           input logic fs, input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] er, input logic [63:0] eb);
        drive(2'd0, op, use_imm, imm, 16'h0, 2'd0, fs, rs1, rs2, rd, a, b, er, eb);
    endtask

    task automatic alu(input logic [2:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic use_imm, input logic [63:0] imm,
                       input logic fs, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] er, input logic [63:0] eb);
        set_alu(op, rs1, rs2, rd, use_imm, imm, fs, a, b, er, eb);
        wait_accept();
    endtask

    // MOVs are issued with flagset=1 to show they never touch NZCV.
    task automatic mov(input logic [1:0] mode, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic [15:0] imm16, input logic [1:0] shamt,
                       input logic [63:0] b, input logic [63:0] er, input logic [63:0] eb);
        drive(mode, AluPassB, 1'b0, 64'h0, imm16, shamt, 1'b1, 5'd31, rs2, rd, 64'h0, b, er, eb);
        wait_accept();
    endtask

    task automatic drain();
        logic done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            done = (sb.size() == 0) && !out_valid;
        end
        check("drain_idle", 64'(done), 64'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; out_ready = 1'b1;
        drive(2'd0, AluAdd, 1'b0, 64'h0, 16'h0, 2'd0, 1'b0, 5'd31, 5'd31, 5'd0,
              64'h0, 64'h0, 64'h0, 64'h0);
        in_valid = 1'b0;
        #3;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_result", out_result, 64'h0);
        check("rst_flags", 64'(flags_q), 64'h0);
        @(posedge clk);
        #1 reset = 1'b1;
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // x1 = xzr + 7: result visible after the edge following the accept edge
        alu(AluAdd, 5'd31, 5'd31, 5'd1, 1'b1, 64'd7, 1'b1, 64'h0, 64'h0, 64'd7, 64'h0);
        check("lat_not_yet", 64'(out_valid), 64'd0);
        check("zero_check_x1", 64'(zero_check), 64'd0);
        @(posedge clk);
        #1;
        check("lat_valid", 64'(out_valid), 64'd1);
        check("lat_result", out_result, 64'd7);
        drain();
        check("flags_x1", 64'(flags_q), 64'h0);

        // Back-to-back dependent stream with stale regfile data
        alu(AluAdd, 5'd31, 5'd31, 5'd1, 1'b1, 64'd7, 1'b1, 64'h0, 64'h0, 64'd7, 64'h0);
        alu(AluAdd, 5'd1, 5'd1, 5'd2, 1'b0, 64'h0, 1'b0, 64'h0, 64'h0, 64'd14, 64'd7);
        alu(AluSub, 5'd2, 5'd1, 5'd3, 1'b0, 64'h0, 1'b0, 64'h0, 64'h0, 64'd7, 64'd7);
        alu(AluSub, 5'd1, 5'd1, 5'd4, 1'b0, 64'h0, 1'b1, 64'd7, 64'd7, 64'd0, 64'd7);
        check("zero_check_x4", 64'(zero_check), 64'd1);
        drain();
        check("flags_sub_zero", 64'(flags_q), 64'b0110);

        // Signed overflow, then unsigned wrap
        alu(AluAdd, 5'd6, 5'd31, 5'd5, 1'b1, 64'd1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0,
            64'h8000_0000_0000_0000, 64'h0);
        drain();
        check("flags_overflow", 64'(flags_q), 64'b1001);
        alu(AluAdd, 5'd9, 5'd31, 5'd8, 1'b1, 64'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,
            64'h0, 64'h0);
        drain();
        check("flags_wrap", 64'(flags_q), 64'b0110);

        // MOVZ then dependent MOVK via forwarding; flags must not move
        mov(2'd1, 5'd31, 5'd7, 16'hBEEF, 2'd2, 64'h0, 64'h0000_BEEF_0000_0000, 64'h0);
        mov(2'd2, 5'd7, 5'd7, 16'h1234, 2'd0, 64'h0, 64'h0000_BEEF_0000_1234,
            64'h0000_BEEF_0000_0000);
        drain();
        check("flags_after_mov", 64'(flags_q), 64'b0110);

        // Logic op with flagset clears C and V
        alu(AluXor, 5'd21, 5'd22, 5'd23, 1'b0, 64'h0, 1'b1, 64'hF0F0, 64'hFFFF,
            64'h0F0F, 64'hFFFF);
        drain();
        check("flags_xor", 64'(flags_q), 64'b0000);

        // Backpressure: two accepts fill the pipe, outputs hold while stalled
        out_ready = 1'b0;
        alu(AluAdd, 5'd31, 5'd31, 5'd10, 1'b1, 64'd100, 1'b0, 64'h0, 64'h0, 64'd100, 64'h0);
        alu(AluAdd, 5'd31, 5'd31, 5'd11, 1'b1, 64'd200, 1'b0, 64'h0, 64'h0, 64'd200, 64'h0);
        set_alu(AluAdd, 5'd31, 5'd31, 5'd12, 1'b1, 64'd300, 1'b0, 64'h0, 64'h0, 64'd300, 64'h0);
        check("bp_in_ready_low", 64'(in_ready), 64'd0);
        check("bp_out_valid", 64'(out_valid), 64'd1);
        check("bp_result", out_result, 64'd100);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check("bp_result_stable", out_result, 64'd100);
            check("bp_rd_stable", 64'(out_rd), 64'd10);
            check("bp_in_ready_held", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        wait_accept();
        drain();

        // Flush with B full and a flagset subtract in A; the concurrent issue is dropped
        out_ready = 1'b0;
        alu(AluAdd, 5'd31, 5'd31, 5'd13, 1'b1, 64'd5, 1'b0, 64'h0, 64'h0, 64'd5, 64'h0);
        alu(AluSub, 5'd31, 5'd31, 5'd14, 1'b1, 64'd1, 1'b1, 64'h0, 64'h0,
            64'hFFFF_FFFF_FFFF_FFFF, 64'h0);
        set_alu(AluAdd, 5'd31, 5'd31, 5'd20, 1'b1, 64'd77, 1'b0, 64'h0, 64'h0, 64'd77, 64'h0);
        flush = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_flags", 64'(flags_q), 64'b0000);
        check("flush_in_ready", 64'(in_ready), 64'd1);
        drain();
        alu(AluAdd, 5'd31, 5'd31, 5'd15, 1'b1, 64'd9, 1'b0, 64'h0, 64'h0, 64'd9, 64'h0);
        drain();

        // Asynchronous reset with work in flight
        alu(AluSub, 5'd31, 5'd31, 5'd16, 1'b1, 64'd1, 1'b1, 64'h0, 64'h0,
            64'hFFFF_FFFF_FFFF_FFFF, 64'h0);
        alu(AluAdd, 5'd31, 5'd31, 5'd17, 1'b1, 64'd3, 1'b0, 64'h0, 64'h0, 64'd3, 64'h0);
        check("pre_rst_flags", 64'(flags_q), 64'b1000);
        check("pre_rst_valid", 64'(out_valid), 64'd1);
        #1;
        reset = 1'b0;
        sb.delete();
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_out_result", out_result, 64'h0);
        check("arst_out_b", out_b, 64'h0);
        check("arst_out_rd", 64'(out_rd), 64'd0);
        check("arst_out_rd_we", 64'(out_rd_we), 64'd0);
        check("arst_flags", 64'(flags_q), 64'h0);
        @(posedge clk);
        #1 reset = 1'b1;
        check("arst_in_ready", 64'(in_ready), 64'd1);
        alu(AluAdd, 5'd31, 5'd31, 5'd18, 1'b1, 64'd42, 1'b0, 64'h0, 64'h0, 64'd42, 64'h0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
